// File: rtl/score_sequencer.sv
// score_sequencer: owns the BCD game score and best score, and sequences the
// two-digit active-low 7-segment display through play, flash and best-score views.
module score_sequencer #(
    parameter int BLINK_PERIOD = 12_500_000,
    parameter int FLASH_COUNT  = 6,
    parameter int MAX_SCORE    = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic       i_Point,
    input  logic       i_Game_Over,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2,
    output logic [6:0] o_Score,
    output logic [6:0] o_Best,
    output logic       o_Playing
);

    localparam int TM_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int PH_W = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

    localparam logic [TM_W-1:0] TM_LAST = TM_W'(BLINK_PERIOD - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_COUNT - 1);
    localparam logic [3:0]      MAX_T   = 4'(MAX_SCORE / 10);
    localparam logic [3:0]      MAX_O   = 4'(MAX_SCORE % 10);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_FLASH     = 2'd2,
        S_SHOW_BEST = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [3:0]      r_best_tens;
    logic [3:0]      r_best_ones;
    logic [TM_W-1:0] r_timer;
    logic [PH_W-1:0] r_phase;

    logic [6:0]      r_seg1;
    logic [6:0]      r_seg2;
    logic [6:0]      r_score;
    logic [6:0]      r_best;
    logic            r_playing;

    logic            w_at_max;
    logic            w_inc;
    logic            w_tick;
    logic            w_clr_score;
    logic            w_upd_best;
    logic            w_flash_enter;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;
    logic [6:0]      w_disp1;
    logic [6:0]      w_disp2;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Two-digit BCD to binary using tens*8 + tens*2 + ones, avoiding a multiplier.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
        return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, o};
    endfunction

    // Saturating BCD increment: only PLAY counts points, and never past MAX_SCORE.
    assign w_at_max   = (r_tens == MAX_T) && (r_ones == MAX_O);
    assign w_inc      = (r_state == S_PLAY) && i_Point && !w_at_max;
    assign w_ones_nxt = !w_inc ? r_ones : ((r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1);
    assign w_tens_nxt = !w_inc ? r_tens : ((r_ones == 4'd9) ? r_tens + 4'd1 : r_tens);
    assign w_tick     = (r_timer == TM_LAST);

    // Next-state and control strobes; best compare sees the score after this edge's point.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_score   = 1'b0;
        w_upd_best    = 1'b0;
        w_flash_enter = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_state_nxt = S_PLAY;
                    w_clr_score = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_Game_Over) begin
                    w_state_nxt   = S_FLASH;
                    w_flash_enter = 1'b1;
                    w_upd_best    = ({w_tens_nxt, w_ones_nxt} > {r_best_tens, r_best_ones});
                end
            end
            S_FLASH: begin
                if (w_tick && (r_phase == PH_LAST)) begin
                    w_state_nxt = S_SHOW_BEST;
                end
            end
            S_SHOW_BEST: begin
                if (i_Start) begin
                    w_state_nxt = S_PLAY;
                    w_clr_score = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Current score and best score, both held as BCD digit pairs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_best_tens <= 4'd0;
            r_best_ones <= 4'd0;
        end else begin
            if (w_clr_score) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else begin
                r_tens <= w_tens_nxt;
                r_ones <= w_ones_nxt;
            end
            if (w_upd_best) begin
                r_best_tens <= w_tens_nxt;
                r_best_ones <= w_ones_nxt;
            end
        end
    end

    // Blink timer and phase counter; restarted on each entry to FLASH, idle elsewhere.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_timer <= '0;
            r_phase <= '0;
        end else if (w_flash_enter) begin
            r_timer <= '0;
            r_phase <= '0;
        end else if (r_state == S_FLASH) begin
            if (w_tick) begin
                r_timer <= '0;
                r_phase <= r_phase + 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Display source selection: score, blank on odd flash phases, or best score.
    always_comb begin
        w_disp1 = seg7(r_tens);
        w_disp2 = seg7(r_ones);
        case (r_state)
            S_FLASH: begin
                if (r_phase[0]) begin
                    w_disp1 = SEG_BLANK;
                    w_disp2 = SEG_BLANK;
                end
            end
            S_SHOW_BEST: begin
                w_disp1 = seg7(r_best_tens);
                w_disp2 = seg7(r_best_ones);
            end
            default: ;
        endcase
    end

    // Single output register stage: every output trails the internal state by one edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_seg1    <= SEG_ZERO;
            r_seg2    <= SEG_ZERO;
            r_score   <= 7'd0;
            r_best    <= 7'd0;
            r_playing <= 1'b0;
        end else begin
            r_seg1    <= w_disp1;
            r_seg2    <= w_disp2;
            r_score   <= bcd_to_bin(r_tens, r_ones);
            r_best    <= bcd_to_bin(r_best_tens, r_best_ones);
            r_playing <= (r_state == S_PLAY);
        end
    end

    assign o_Segment1 = r_seg1;
    assign o_Segment2 = r_seg2;
    assign o_Score    = r_score;
    assign o_Best     = r_best;
    assign o_Playing  = r_playing;

endmodule
